// File: rtl/fib_pkg.sv
// fib_pkg: shared types for the Fibonacci sweep block.
//   fib_state_e      - sweep controller states
//   fib_entry_t      - one result entry {n, result, overflow} at the default widths
//   fib_entry_width  - packed entry width for any INPUT_WIDTH/OUTPUT_WIDTH pair
// Entries are always packed in the field order of fib_entry_t, with n in the MSBs
// and overflow in the LSB.
package fib_pkg;

  localparam int FIB_INPUT_WIDTH  = 6;
  localparam int FIB_OUTPUT_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CLEAR,
    WAIT,
    PUSH,
    FINISH
  } fib_state_e;

  typedef struct packed {
    logic [FIB_INPUT_WIDTH-1:0]  n;
    logic [FIB_OUTPUT_WIDTH-1:0] result;
    logic                        overflow;
  } fib_entry_t;

  function automatic int fib_entry_width(input int iw, input int ow);
    return iw + ow + 1;
  endfunction

endpackage

// File: rtl/fib_result_fifo.sv
// fib_result_fifo: synchronous FIFO holding sweep result entries.
//   clk, rst         - clock, asynchronous active-high reset (empties the FIFO)
//   push, wr_data    - write request and entry; accepted when not full, or when
//                      full and a pop happens in the same cycle
//   pop              - remove the head entry (ignored when empty)
//   rd_data          - head entry (meaningful only while empty=0)
//   full, empty      - occupancy flags
module fib_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 39
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Storage needs no reset: nothing reads it while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/fib_sweep.sv
// fib_sweep: drives an external Fibonacci core over the index range
// n_start..n_end and queues each {n, result, overflow} in an output FIFO.
//   clk, rst                  - clock, asynchronous active-high reset
//   go, n_start, n_end        - sweep request (accepted only in IDLE/FINISH)
//   core_go, core_n           - start pulse and index to the core
//   core_result, core_overflow, core_done - core response
//   out_valid, out_ready      - FIFO head handshake
//   out_n, out_result, out_overflow - FIFO head fields (0 while empty)
//   done                      - sweep finished (high while in FINISH)
//   sweep_overflow            - current/last sweep stopped on overflow
module fib_sweep
  import fib_pkg::*;
#(
  parameter int INPUT_WIDTH  = 6,
  parameter int OUTPUT_WIDTH = 32,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    go,
  input  logic [INPUT_WIDTH-1:0]  n_start,
  input  logic [INPUT_WIDTH-1:0]  n_end,
  output logic                    core_go,
  output logic [INPUT_WIDTH-1:0]  core_n,
  input  logic [OUTPUT_WIDTH-1:0] core_result,
  input  logic                    core_overflow,
  input  logic                    core_done,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [INPUT_WIDTH-1:0]  out_n,
  output logic [OUTPUT_WIDTH-1:0] out_result,
  output logic                    out_overflow,
  output logic                    done,
  output logic                    sweep_overflow
);

  localparam int ENTRY_W = fib_entry_width(INPUT_WIDTH, OUTPUT_WIDTH);

  fib_state_e              state_reg;
  fib_state_e              state_next;
  logic [INPUT_WIDTH-1:0]  idx_reg;
  logic [INPUT_WIDTH-1:0]  n_end_reg;
  logic [OUTPUT_WIDTH-1:0] cap_result_reg;
  logic                    cap_ovf_reg;
  logic                    sweep_ovf_reg;

  logic                    accept_go;
  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    can_push;
  logic [ENTRY_W-1:0]      wr_data;
  logic [ENTRY_W-1:0]      rd_data;

  assign fifo_pop = !fifo_empty && out_ready;
  assign can_push = !fifo_full || fifo_pop;
  assign wr_data  = {idx_reg, cap_result_reg, cap_ovf_reg};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    core_go    = 1'b0;
    fifo_push  = 1'b0;
    accept_go  = 1'b0;
    case (state_reg)
      IDLE, FINISH: begin
        if (go) begin
          accept_go  = 1'b1;
          state_next = (n_start > n_end) ? FINISH : ISSUE;
        end
      end
      ISSUE: begin
        core_go    = 1'b1;
        state_next = CLEAR;
      end
      CLEAR: begin
        // Let the previous result's done drop before looking for a new one.
        if (!core_done) state_next = WAIT;
      end
      WAIT: begin
        if (core_done) state_next = PUSH;
      end
      PUSH: begin
        if (can_push) begin
          fifo_push = 1'b1;
          // Last-index test uses idx before increment, so n_end at the top
          // of the index range terminates without wrapping.
          if (cap_ovf_reg || (idx_reg == n_end_reg)) state_next = FINISH;
          else                                      state_next = ISSUE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_reg        <= '0;
      n_end_reg      <= '0;
      cap_result_reg <= '0;
      cap_ovf_reg    <= 1'b0;
      sweep_ovf_reg  <= 1'b0;
    end else begin
      if (accept_go) begin
        idx_reg       <= n_start;
        n_end_reg     <= n_end;
        sweep_ovf_reg <= 1'b0;
      end
      if ((state_reg == WAIT) && core_done) begin
        cap_result_reg <= core_result;
        cap_ovf_reg    <= core_overflow;
      end
      if (fifo_push) begin
        if (cap_ovf_reg)                 sweep_ovf_reg <= 1'b1;
        else if (idx_reg != n_end_reg)   idx_reg       <= idx_reg + 1'b1;
      end
    end
  end

  fib_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data (wr_data),
    .pop     (fifo_pop),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // idx holds steady from ISSUE through capture, so it doubles as core_n.
  assign core_n         = idx_reg;
  assign done           = (state_reg == FINISH);
  assign sweep_overflow = sweep_ovf_reg;
  assign out_valid      = !fifo_empty;
  assign {out_n, out_result, out_overflow} = fifo_empty ? '0 : rd_data;

endmodule

// File: tb/tb_fib_sweep.sv
// tb_fib_sweep: randomized self-checking bench for fib_sweep with a compliant
// Fibonacci core model and a sequence-level reference of expected entries.
module tb_fib_sweep;

  localparam int IW = 6;
  localparam int OW = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          go = 1'b0;
  logic [IW-1:0] n_start = '0;
  logic [IW-1:0] n_end = '0;
  logic          core_go;
  logic [IW-1:0] core_n;
  logic [OW-1:0] core_result = '0;
  logic          core_overflow = 1'b0;
  logic          core_done = 1'b1;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [IW-1:0] out_n;
  logic [OW-1:0] out_result;
  logic          out_overflow;
  logic          done;
  logic          sweep_overflow;

  int errors = 0;
  int checks = 0;

  fib_sweep #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .go(go), .n_start(n_start), .n_end(n_end),
    .core_go(core_go), .core_n(core_n), .core_result(core_result),
    .core_overflow(core_overflow), .core_done(core_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_n(out_n),
    .out_result(out_result), .out_overflow(out_overflow),
    .done(done), .sweep_overflow(sweep_overflow)
  );

  always #5 clk = ~clk;

  // fib(0)=0, fib(1)=0, fib(2)=1, fib(n)=fib(n-1)+fib(n-2)
  function automatic longint unsigned fib_ref(input int n);
    longint unsigned a, b, c;
    if (n < 2) return 0;
    a = 0;
    b = 1;
    for (int k = 2; k < n; k++) begin
      c = a + b;
      a = b;
      b = c;
    end
    return b;
  endfunction

  function automatic logic [OW-1:0] fib_trunc(input int n);
    longint unsigned v;
    v = fib_ref(n);
    return v[OW-1:0];
  endfunction

  function automatic bit fib_ovf(input int n);
    return fib_ref(n) > 64'h0000_0000_FFFF_FFFF;
  endfunction

  // Core model: done drops the cycle after core_go, result after 1..4 cycles.
  int          core_lat = 0;
  logic        core_busy = 1'b0;
  logic [IW-1:0] core_pend = '0;
  always @(posedge clk) begin
    if (core_go) begin
      core_done <= 1'b0;
      core_pend <= core_n;
      core_lat  <= $urandom_range(0, 3);
      core_busy <= 1'b1;
    end else if (core_busy) begin
      if (core_lat == 0) begin
        core_done     <= 1'b1;
        core_result   <= fib_trunc(int'(core_pend));
        core_overflow <= fib_ovf(int'(core_pend));
        core_busy     <= 1'b0;
      end else begin
        core_lat <= core_lat - 1;
      end
    end
  end

  int core_go_cnt = 0;
  int valid_cnt = 0;
  always @(posedge clk) begin
    if (core_go)   core_go_cnt <= core_go_cnt + 1;
    if (out_valid) valid_cnt   <= valid_cnt + 1;
  end

  int            exp_n[$];
  logic [OW-1:0] exp_r[$];
  bit            exp_o[$];
  int            got_n[$];
  logic [OW-1:0] got_r[$];
  bit            got_o[$];

  // Reference: indices s..e in order, stopping after the first overflowing one.
  task automatic build_expected(input int s, input int e);
    exp_n.delete(); exp_r.delete(); exp_o.delete();
    for (int i = s; i <= e; i++) begin
      exp_n.push_back(i);
      exp_r.push_back(fib_trunc(i));
      exp_o.push_back(fib_ovf(i));
      if (fib_ovf(i)) break;
    end
  endtask

  task automatic start_sweep(input int s, input int e);
    @(negedge clk);
    go = 1'b1;
    n_start = IW'(s);
    n_end = IW'(e);
    @(negedge clk);
    go = 1'b0;
  endtask

  // Pops entries with random back-pressure until done and drained.
  task automatic collect(input int max_cycles, input int ready_pct, input int go_at,
                         output bit timed_out);
    got_n.delete(); got_r.delete(); got_o.delete();
    timed_out = 1'b1;
    for (int c = 0; c < max_cycles; c++) begin
      @(negedge clk);
      go = (c == go_at);
      if (go) begin
        n_start = 6'd30;
        n_end = 6'd31;
      end
      out_ready = ($urandom_range(0, 99) < ready_pct);
      if (out_valid && out_ready) begin
        got_n.push_back(int'(out_n));
        got_r.push_back(out_result);
        got_o.push_back(out_overflow);
      end
      if (done && !out_valid && !go) begin
        timed_out = 1'b0;
        break;
      end
    end
    go = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({core_go, core_n, out_valid, out_n, out_result, out_overflow, done, sweep_overflow} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got go=%b n=%0d v=%b on=%0d r=%0d o=%b d=%b so=%b expected all 0",
               core_go, core_n, out_valid, out_n, out_result, out_overflow, done, sweep_overflow);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({core_go, out_valid, done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle: got core_go=%b out_valid=%b done=%b expected 000", core_go, out_valid, done);
    end
    $display("reset: released, idle checked");
  endtask

  task automatic test_basic();
    bit to;
    logic [OW-1:0] basic_r [5];
    basic_r = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd3};
    start_sweep(1, 5);
    collect(1000, 100, -1, to);
    checks++;
    if (to !== 1'b0 || got_n.size() !== 5) begin
      errors++;
      $display("FAIL basic_count: got %0d entries (timeout=%b) expected 5", got_n.size(), to);
    end
    for (int i = 0; i < got_n.size() && i < 5; i++) begin
      checks++;
      if (got_n[i] !== i + 1 || got_r[i] !== basic_r[i] || got_o[i] !== 1'b0) begin
        errors++;
        $display("FAIL basic_entry[%0d]: got (%0d,%0d,%b) expected (%0d,%0d,0)",
                 i, got_n[i], got_r[i], got_o[i], i + 1, basic_r[i]);
      end
    end
    checks++;
    if (done !== 1'b1 || sweep_overflow !== 1'b0) begin
      errors++;
      $display("FAIL basic_flags: got done=%b sweep_overflow=%b expected 1/0", done, sweep_overflow);
    end
    $display("basic: sweep 1..5 got %0d entries", got_n.size());
  endtask

  task automatic test_overflow();
    bit to;
    build_expected(47, 55);
    start_sweep(47, 55);
    collect(1000, 100, -1, to);
    checks++;
    if (to !== 1'b0 || got_n.size() !== 3) begin
      errors++;
      $display("FAIL ovf_count: got %0d entries (timeout=%b) expected 3", got_n.size(), to);
    end
    if (got_n.size() == 3) begin
      checks++;
      if (got_n[0] !== 47 || got_r[0] !== 32'd1836311903 || got_o[0] !== 1'b0 ||
          got_n[1] !== 48 || got_r[1] !== 32'd2971215073 || got_o[1] !== 1'b0 ||
          got_n[2] !== 49 || got_o[2] !== 1'b1 || got_r[2] !== exp_r[2]) begin
        errors++;
        $display("FAIL ovf_entries: got (%0d,%0d,%b)(%0d,%0d,%b)(%0d,%0d,%b) expected (47,1836311903,0)(48,2971215073,0)(49,%0d,1)",
                 got_n[0], got_r[0], got_o[0], got_n[1], got_r[1], got_o[1],
                 got_n[2], got_r[2], got_o[2], exp_r[2]);
      end
    end
    checks++;
    if (done !== 1'b1 || sweep_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_flags: got done=%b sweep_overflow=%b expected 1/1", done, sweep_overflow);
    end
    $display("overflow: sweep 47..55 got %0d entries", got_n.size());
  endtask

  task automatic test_empty_range();
    int cg0, vc0;
    cg0 = core_go_cnt;
    vc0 = valid_cnt;
    start_sweep(9, 3);
    checks++;
    if (done !== 1'b1 || sweep_overflow !== 1'b0) begin
      errors++;
      $display("FAIL empty_done: got done=%b sweep_overflow=%b expected 1/0 one cycle after go", done, sweep_overflow);
    end
    repeat (12) @(negedge clk);
    checks++;
    if (core_go_cnt !== cg0 || valid_cnt !== vc0 || done !== 1'b1) begin
      errors++;
      $display("FAIL empty_quiet: got core_go pulses=%0d valid cycles=%0d done=%b expected 0/0/1",
               core_go_cnt - cg0, valid_cnt - vc0, done);
    end
    $display("empty_range: sweep 9..3 produced %0d pulses", core_go_cnt - cg0);
  endtask

  task automatic test_backpressure();
    bit to;
    int cg0;
    out_ready = 1'b0;
    cg0 = core_go_cnt;
    start_sweep(1, 10);
    repeat (150) @(negedge clk);
    checks++;
    if (core_go_cnt - cg0 !== DEPTH + 1 || out_valid !== 1'b1 || out_n !== 6'd1 || done !== 1'b0) begin
      errors++;
      $display("FAIL bp_stall: got pulses=%0d out_valid=%b head=%0d done=%b expected %0d/1/1/0",
               core_go_cnt - cg0, out_valid, out_n, done, DEPTH + 1);
    end
    build_expected(1, 10);
    collect(3000, 100, -1, to);
    checks++;
    if (to !== 1'b0 || got_n.size() !== exp_n.size()) begin
      errors++;
      $display("FAIL bp_count: got %0d entries (timeout=%b) expected %0d", got_n.size(), to, exp_n.size());
    end
    for (int i = 0; i < got_n.size() && i < exp_n.size(); i++) begin
      checks++;
      if (got_n[i] !== exp_n[i] || got_r[i] !== exp_r[i] || got_o[i] !== exp_o[i]) begin
        errors++;
        $display("FAIL bp_entry[%0d]: got (%0d,%0d,%b) expected (%0d,%0d,%b)",
                 i, got_n[i], got_r[i], got_o[i], exp_n[i], exp_r[i], exp_o[i]);
      end
    end
    $display("backpressure: sweep 1..10 got %0d entries after release", got_n.size());
  endtask

  task automatic test_random();
    bit to;
    int s, e, pct;
    for (int t = 0; t < 6; t++) begin
      s = $urandom_range(0, 55);
      e = s + $urandom_range(0, 6);
      if (e > 63) e = 63;
      pct = $urandom_range(30, 100);
      build_expected(s, e);
      start_sweep(s, e);
      collect(3000, pct, -1, to);
      checks++;
      if (to !== 1'b0 || got_n.size() !== exp_n.size()) begin
        errors++;
        $display("FAIL rand%0d_count: got %0d entries (timeout=%b) expected %0d", t, got_n.size(), to, exp_n.size());
      end
      for (int i = 0; i < got_n.size() && i < exp_n.size(); i++) begin
        checks++;
        if (got_n[i] !== exp_n[i] || got_r[i] !== exp_r[i] || got_o[i] !== exp_o[i]) begin
          errors++;
          $display("FAIL rand%0d_entry[%0d]: got (%0d,%0d,%b) expected (%0d,%0d,%b)",
                   t, i, got_n[i], got_r[i], got_o[i], exp_n[i], exp_r[i], exp_o[i]);
        end
      end
      checks++;
      if (sweep_overflow !== exp_o[exp_o.size()-1]) begin
        errors++;
        $display("FAIL rand%0d_sweep_ovf: got %b expected %b", t, sweep_overflow, exp_o[exp_o.size()-1]);
      end
      $display("random%0d: sweep %0d..%0d ready=%0d%% got %0d entries", t, s, e, pct, got_n.size());
    end
  endtask

  task automatic test_busy_go();
    bit to;
    build_expected(1, 12);
    start_sweep(1, 12);
    collect(3000, 70, 10, to);
    checks++;
    if (to !== 1'b0 || got_n.size() !== exp_n.size()) begin
      errors++;
      $display("FAIL busy_count: got %0d entries (timeout=%b) expected %0d", got_n.size(), to, exp_n.size());
    end
    for (int i = 0; i < got_n.size() && i < exp_n.size(); i++) begin
      checks++;
      if (got_n[i] !== exp_n[i] || got_r[i] !== exp_r[i] || got_o[i] !== exp_o[i]) begin
        errors++;
        $display("FAIL busy_entry[%0d]: got (%0d,%0d,%b) expected (%0d,%0d,%b)",
                 i, got_n[i], got_r[i], got_o[i], exp_n[i], exp_r[i], exp_o[i]);
      end
    end
    $display("busy_go: sweep 1..12 with go mid-sweep got %0d entries", got_n.size());
  endtask

  task automatic test_reset_midsweep();
    bit to;
    int cg0, vc0;
    out_ready = 1'b0;
    start_sweep(1, 20);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({core_go, core_n, out_valid, out_n, out_result, out_overflow, done, sweep_overflow} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: got go=%b n=%0d v=%b on=%0d r=%0d o=%b d=%b so=%b expected all 0",
               core_go, core_n, out_valid, out_n, out_result, out_overflow, done, sweep_overflow);
    end
    @(negedge clk);
    rst = 1'b0;
    cg0 = core_go_cnt;
    vc0 = valid_cnt;
    out_ready = 1'b1;
    repeat (30) @(negedge clk);
    checks++;
    if (core_go_cnt !== cg0 || valid_cnt !== vc0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midrst_abandon: got pulses=%0d valid cycles=%0d done=%b expected 0/0/0",
               core_go_cnt - cg0, valid_cnt - vc0, done);
    end
    build_expected(62, 63);
    start_sweep(62, 63);
    collect(1000, 100, -1, to);
    checks++;
    if (to !== 1'b0 || got_n.size() !== exp_n.size()) begin
      errors++;
      $display("FAIL top_count: got %0d entries (timeout=%b) expected %0d", got_n.size(), to, exp_n.size());
    end
    for (int i = 0; i < got_n.size() && i < exp_n.size(); i++) begin
      checks++;
      if (got_n[i] !== exp_n[i] || got_r[i] !== exp_r[i] || got_o[i] !== exp_o[i]) begin
        errors++;
        $display("FAIL top_entry[%0d]: got (%0d,%0d,%b) expected (%0d,%0d,%b)",
                 i, got_n[i], got_r[i], got_o[i], exp_n[i], exp_r[i], exp_o[i]);
      end
    end
    repeat (10) @(negedge clk);
    checks++;
    if (done !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL top_finish: got done=%b out_valid=%b expected 1/0", done, out_valid);
    end
    $display("reset_midsweep: sweep 62..63 after reset got %0d entries", got_n.size());
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_empty_range();
    test_backpressure();
    test_random();
    test_busy_go();
    test_reset_midsweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
